// File: rtl/vga_timing_if.sv
// vga_timing_if: bundles the run enable and every timing output of vga_timing.
//   master  - the timing generator: takes en, drives counters, syncs and strobes.
//   slave   - a consumer (pixel pipeline or bench): drives en, observes the rest.
// Signals:
//   en           run enable; low freezes the generator
//   hcount[9:0]  current pixel column
//   vcount[9:0]  current line
//   hsync/vsync  active-low sync pulses
//   bright       high inside the visible area
//   pix_en       one-clk strobe per pixel advance
//   frame_start  one-clk strobe after the counters wrap to (0,0)
//   frame_cnt    16-bit frame counter, only when VGA_TIMING_FRAME_CNT_EN is defined
interface vga_timing_if;
  logic        en;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        hsync;
  logic        vsync;
  logic        bright;
  logic        pix_en;
  logic        frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
    input  en,
    output hcount, vcount, hsync, vsync, bright, pix_en, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output en,
    input  hcount, vcount, hsync, vsync, bright, pix_en, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: VGA raster timing generator. A clock divider produces one pixel
// strobe every CLK_DIV clocks; horizontal and vertical counters walk the raster
// and registered hsync/vsync/bright are derived from the next-state counters so
// they line up with hcount/vcount in the same cycle.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   vga    vga_timing_if.master (en in; hcount, vcount, hsync, vsync, bright,
//          pix_en, frame_start out; frame_cnt out when enabled)
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt
// output; without it the port and its register do not exist.
module vga_timing #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33
) (
  input logic          clk,
  input logic          rst_n,
  vga_timing_if.master vga
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivMax    = DivW'(CLK_DIV - 1);
  localparam logic [9:0]      HMax      = 10'(H_TOTAL - 1);
  localparam logic [9:0]      VMax      = 10'(V_TOTAL - 1);
  localparam logic [9:0]      HVis      = 10'(H_VIS);
  localparam logic [9:0]      VVis      = 10'(V_VIS);
  localparam logic [9:0]      HSyncBeg  = 10'(H_VIS + H_FP);
  localparam logic [9:0]      HSyncEnd  = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]      VSyncBeg  = 10'(V_VIS + V_FP);
  localparam logic [9:0]      VSyncEnd  = 10'(V_VIS + V_FP + V_SYNC);

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      hcount_q, hcount_d;
  logic [9:0]      vcount_q, vcount_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            bright_q, bright_d;
  logic            frame_start_q, frame_start_d;
  logic            pix_en;
  logic            h_wrap, v_wrap;

  // Gated by rst_n so the strobe is low during reset even when CLK_DIV == 1.
  assign pix_en = rst_n & vga.en & (div_q == DivMax);
  assign h_wrap = (hcount_q == HMax);
  assign v_wrap = (vcount_q == VMax);

  always_comb begin
    div_d         = div_q;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    bright_d      = bright_q;
    frame_start_d = 1'b0;

    if (vga.en) begin
      div_d = (div_q == DivMax) ? '0 : div_q + 1'b1;
    end

    if (pix_en) begin
      if (h_wrap) begin
        hcount_d = '0;
        vcount_d = v_wrap ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
      // Decode from the next-state counters so the registered flags match them.
      hsync_d       = !((hcount_d >= HSyncBeg) && (hcount_d < HSyncEnd));
      vsync_d       = !((vcount_d >= VSyncBeg) && (vcount_d < VSyncEnd));
      bright_d      = (hcount_d < HVis) && (vcount_d < VVis);
      frame_start_d = h_wrap && v_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      bright_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      bright_q      <= bright_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.hcount      = hcount_q;
  assign vga.vcount      = vcount_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.bright      = bright_q;
  assign vga.pix_en      = pix_en;
  // Strobe is suppressed while paused.
  assign vga.frame_start = frame_start_q & vga.en;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Advances on the same edge that sets frame_start_q; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule
